// File: rtl/zap_predecode_bpred.sv
// Branch prediction and output register at the tail of predecode: a table of 2-bit
// saturating counters, walked to INIT_STATE after reset, trained by ALU resolution.
module zap_predecode_bpred #(
    parameter int BHT_ENTRIES = 256,
    parameter int INSTR_W     = 36,
    parameter int INIT_STATE  = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clear_from_writeback,
    input  logic               i_data_stall,
    input  logic               i_clear_from_alu,
    input  logic               i_stall_from_shifter,
    input  logic               i_stall_from_issue,
    input  logic [31:0]        i_pc_ff,
    input  logic [31:0]        i_pc_plus_8_ff,
    input  logic [INSTR_W-1:0] i_instruction,
    input  logic               i_instruction_valid,
    input  logic               i_upd_valid,
    input  logic [31:0]        i_upd_pc,
    input  logic               i_upd_taken,
    output logic [INSTR_W-1:0] o_instruction_ff,
    output logic               o_instruction_valid_ff,
    output logic [31:0]        o_pc_ff,
    output logic [31:0]        o_pc_plus_8_ff,
    output logic [1:0]         o_taken_ff,
    output logic               o_clear_from_decode,
    output logic [31:0]        o_pc_from_decode,
    output logic               o_stall_from_bpred
);
    localparam int         IDX_W    = $clog2(BHT_ENTRIES);
    localparam logic [1:0] INIT_CTR = 2'(INIT_STATE);
    localparam logic [3:0] COND_AL  = 4'hE;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t           state;
    logic [IDX_W-1:0] init_cnt;
    logic [1:0]       bht [BHT_ENTRIES];

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [1:0]       ctr, taken_nxt;
    logic             run, is_br, is_al, hold, flush, clr, hld;
    logic [31:0]      off_se, off, target;
    logic             unused_bits;

    // Halfword-granular index shared by lookup and training.
    assign lk_idx = i_pc_ff[IDX_W:1];
    assign up_idx = i_upd_pc[IDX_W:1];
    assign run    = (state == S_RUN);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= S_INIT;
            init_cnt <= '0;
        end else if (state == S_INIT) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == IDX_W'(BHT_ENTRIES - 1))
                state <= S_RUN;
        end
    end

    // Table carries no reset; the init walk gives every entry a defined value.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if (state == S_INIT)
                bht[init_cnt] <= INIT_CTR;
            else if (i_upd_valid) begin
                if (i_upd_taken && bht[up_idx] != 2'd3)
                    bht[up_idx] <= bht[up_idx] + 2'd1;
                else if (!i_upd_taken && bht[up_idx] != 2'd0)
                    bht[up_idx] <= bht[up_idx] - 2'd1;
            end
        end
    end

    assign ctr    = bht[lk_idx];
    assign is_br  = i_instruction_valid && (i_instruction[27:25] == 3'b101);
    assign is_al  = (i_instruction[31:28] == COND_AL);
    assign off_se = {{8{i_instruction[23]}}, i_instruction[23:0]};
    assign off    = i_instruction[34] ? {off_se[30:0], 1'b0} : {off_se[29:0], 2'b00};
    assign target = i_pc_plus_8_ff + off;
    assign hold   = i_data_stall | i_stall_from_shifter | i_stall_from_issue;
    assign flush  = i_clear_from_writeback | i_clear_from_alu;

    assign o_clear_from_decode = run && is_br && (ctr[1] || is_al) && !hold && !flush;
    assign o_pc_from_decode    = o_clear_from_decode ? target : 32'd0;
    assign o_stall_from_bpred  = !run;

    always_comb begin
        taken_nxt = 2'd0;
        if (run && is_br)
            taken_nxt = is_al ? 2'd3 : ctr;
    end

    // A data stall shields the register from an ALU clear; a writeback clear wins over all.
    assign clr = i_reset | i_clear_from_writeback | !run | (!i_data_stall & i_clear_from_alu);
    assign hld = i_data_stall | i_stall_from_shifter | i_stall_from_issue;

    always_ff @(posedge i_clk) begin
        if (clr) begin
            o_instruction_ff       <= '0;
            o_instruction_valid_ff <= 1'b0;
            o_pc_ff                <= 32'd0;
            o_pc_plus_8_ff         <= 32'd8;
            o_taken_ff             <= 2'd0;
        end else if (!hld) begin
            o_instruction_ff       <= i_instruction;
            o_instruction_valid_ff <= i_instruction_valid;
            o_pc_ff                <= i_pc_ff;
            o_pc_plus_8_ff         <= i_pc_plus_8_ff;
            o_taken_ff             <= taken_nxt;
        end
    end

    assign unused_bits = ^{i_instruction, i_pc_ff, i_upd_pc};
endmodule

// File: doc/zap_predecode_bpred.md
Name: zap_predecode_bpred

Overview:
- Parametrised branch-prediction and output-register stage at the tail of the predecode pipeline, directly before issue.
- Holds a BHT_ENTRIES-deep table of 2-bit saturating counters.
  - Looks up the table by fetch PC.
  - Issues an early redirect (clear + target) for predicted-taken branches.
  - Trains the table from ALU branch resolution.
- Replaces the fixed external-taken-state scheme with an internal, depth-configurable table and a hardware init walk after reset.

Parameters:
- BHT_ENTRIES, 256, number of counters; power of two, >= 2. IDX_W = clog2(BHT_ENTRIES).
- INSTR_W, 36, width of the instruction bus passed through.
- INIT_STATE, 1, counter value written during the init walk (0=SNT, 1=WNT, 2=WT, 3=ST).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_clear_from_writeback  in  1  flush, highest priority
- i_data_stall  in  1  hold
- i_clear_from_alu  in  1  flush
- i_stall_from_shifter  in  1  hold
- i_stall_from_issue  in  1  hold, lowest priority
- i_pc_ff  in  32  PC of incoming instruction
- i_pc_plus_8_ff  in  32  PC+8 of incoming instruction
- i_instruction  in  INSTR_W  instruction; [34]=halfword-offset flag, [31:28]=cond, [27:25]=class, [23:0]=offset
- i_instruction_valid  in  1  instruction valid
- i_upd_valid  in  1  resolution update strobe from ALU
- i_upd_pc  in  32  PC of resolved branch
- i_upd_taken  in  1  actual outcome
- o_instruction_ff  out  INSTR_W  registered instruction
- o_instruction_valid_ff  out  1  registered valid
- o_pc_ff  out  32  registered PC
- o_pc_plus_8_ff  out  32  registered PC+8
- o_taken_ff  out  2  registered prediction state
- o_clear_from_decode  out  1  combinational redirect request
- o_pc_from_decode  out  32  combinational redirect target
- o_stall_from_bpred  out  1  high while init walk runs

Behaviour:
- Reset is synchronous, active-high, on i_clk.
- Reset values:
  - o_instruction_ff=0, o_instruction_valid_ff=0, o_pc_ff=0.
  - o_pc_plus_8_ff=32'd8, o_taken_ff=0.
  - FSM=INIT, init counter=0.
- Index is pc[IDX_W:1] (halfword granular) for both lookup and update.

FSM:
- INIT:
  - Each cycle writes INIT_STATE to entry[init_cnt]; init_cnt increments.
  - o_stall_from_bpred=1, o_clear_from_decode=0.
  - Output register is loaded with zeros (valid=0) and i_upd_valid is ignored.
  - After writing entry BHT_ENTRIES-1 -> RUN. The walk takes exactly BHT_ENTRIES cycles after reset deasserts.
- RUN: o_stall_from_bpred=0. Reset asserted mid-walk or in RUN restarts INIT from 0.

Lookup and redirect (combinational, RUN only):
- ctr = entry[i_pc_ff index], read asynchronously.
- is_br = i_instruction_valid && i_instruction[27:25]==3'b101.
- off = sign-extend(i_instruction[23:0]) to 32 bits, shifted left by 1 if [34] else by 2.
- target = i_pc_plus_8_ff + off, modulo 2^32.
- hold = i_data_stall|i_stall_from_shifter|i_stall_from_issue; flush = i_clear_from_writeback|i_clear_from_alu.
- o_clear_from_decode = is_br && (ctr[1] || cond==AL) && !hold && !flush.
- o_pc_from_decode = target when o_clear_from_decode, else 0.
- taken_nxt = ST when is_br && cond==AL; ctr when is_br; 0 otherwise.

Update (RUN):
- On i_upd_valid, entry[i_upd_pc index] moves +1 if i_upd_taken, -1 otherwise, saturating at 0 and 3.
- Updates are applied regardless of stalls and clears.
- Same-cycle lookup of the same index returns the pre-update value (no bypass).

Output register priority, per clock:
1. reset: reset values.
2. clear_wb: clear.
3. data_stall: hold.
4. clear_alu: clear.
5. shifter stall: hold.
6. issue stall: hold.
7. Otherwise load: i_instruction, i_instruction_valid, i_pc_ff, i_pc_plus_8_ff, taken_nxt.

- Clear values equal the reset values; FSM state is unaffected by clears.

Test Plan:
- Init walk: BHT_ENTRIES=8, release reset -> o_stall_from_bpred high exactly 8 cycles; an update pulse during the walk is ignored; all entries read 1.
- AL branch: pc_plus_8=0x108, instr=0xEA000004 -> o_clear_from_decode=1, target 0x118, o_taken_ff=3 next cycle.
- Counter training: cond=EQ branch at pc 0x40, two i_upd_taken=1 pulses -> ctr 1->2->3. A lookup now redirects; three not-taken updates -> 0 (saturated), no redirect.
- Halfword offset: [34]=1, offset 0xFFFFFE, pc_plus_8=0x1000 -> target 0x0FFC; with [34]=0 -> target 0x0FF8.
- Priority: data_stall and clear_from_alu together -> register holds, no redirect. clear_from_writeback with data_stall -> register cleared, o_pc_plus_8_ff=8.
- Aliasing/bypass: lookup and update at same index in one cycle -> redirect uses old ctr; next cycle uses updated ctr. PCs 0x0 and 2*BHT_ENTRIES share an entry.
